debug_unit: RTL and testbench

- Host-side initiator for the top_mips debug interface.
- Consumes a byte command stream from a UART receiver (valid/ready) and drives the processor's debug ports: instruction-memory writes, register-file writes, register-file reads and run/step enable.
- Serializes read-back data to a UART transmitter.
- Sits between the UART and top_mips, so the bench stimulus currently hand-driven on those ports becomes protocol-driven.

---
 rtl/debug_pkg.sv | 25 ++
 rtl/debug_unit_if.sv | 21 ++
 rtl/debug_word_serializer.sv | 58 +++++
 rtl/debug_unit.sv | 191 +++++++++++++++++++
 tb/tb_debug_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared opcodes, state encoding and counter width for debug_unit
package debug_pkg;

  localparam logic [7:0] CMD_LOAD_INST = 8'h01;
  localparam logic [7:0] CMD_WRITE_REG = 8'h02;
  localparam logic [7:0] CMD_READ_REG  = 8'h03;
  localparam logic [7:0] CMD_RUN       = 8'h04;
  localparam logic [7:0] CMD_STOP      = 8'h05;
  localparam logic [7:0] CMD_STEP      = 8'h06;

  localparam int BYTE_CNT_W = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ARG,
    S_GET_DATA,
    S_DO_WRITE,
    S_READ_SETTLE,
    S_READ_CAPTURE,
    S_SEND,
    S_STEP
  } state_t;

endpackage

// File: rtl/debug_unit_if.sv
// rtl/debug_unit_if.sv - UART-side byte streams between debug_unit and the host link
interface debug_unit_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_rx_ready;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready,
    output o_rx_ready, o_tx_data, o_tx_valid
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready,
    input  o_rx_ready, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - emits a loaded word as bytes, MSB first, under valid/ready
module debug_word_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_done
);

  logic [NB_DATA-1:0]    word_q, word_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    o_done = 1'b0;
    if (i_load) begin
      word_d = i_word;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q && i_tx_ready) begin
      // shifting also on the last byte leaves the tx bus at zero when idle
      word_d = word_q << NB_BYTE;
      if (cnt_q == BYTE_CNT_W'(WORD_BYTES - 1)) begin
        busy_d = 1'b0;
        o_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign o_tx_data  = word_q[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid = busy_q;

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART command decoder driving the top_mips debug ports
module debug_unit
  import debug_pkg::*;
#(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  debug_unit_if.slave        uart,
  output logic               o_enable,
  output logic               o_write,
  output logic [NB_ADDR-1:0] o_address,
  output logic [NB_INST-1:0] o_instruction,
  output logic               o_write_debug_reg_file,
  output logic [NB_REG-1:0]  o_address_write_debug,
  output logic [NB_DATA-1:0] o_write_data_debug,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic               o_running,
  output logic               o_cmd_error
);

  localparam int NB_SHIFT = NB_DATA - NB_BYTE;

  state_t                state_q, state_d;
  logic [NB_BYTE-1:0]    opcode_q, opcode_d;
  logic [NB_BYTE-1:0]    arg_q, arg_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [NB_SHIFT-1:0]   data_q, data_d;
  logic                  running_q, running_d;
  logic                  cmd_error_q, cmd_error_d;
  logic                  write_q, write_d;
  logic [NB_ADDR-1:0]    address_q, address_d;
  logic [NB_INST-1:0]    instruction_q, instruction_d;
  logic                  wreg_q, wreg_d;
  logic [NB_REG-1:0]     waddr_q, waddr_d;
  logic [NB_DATA-1:0]    wdata_q, wdata_d;
  logic [NB_REG-1:0]     raddr_q, raddr_d;

  logic               rx_ready;
  logic               rx_fire;
  logic [NB_DATA-1:0] word_in;
  logic               ser_done;

  assign rx_ready = !i_reset &&
                    (state_q == S_IDLE || state_q == S_GET_ARG || state_q == S_GET_DATA);
  assign rx_fire  = uart.i_rx_valid && rx_ready;
  assign word_in  = {data_q, uart.i_rx_data};

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    arg_d         = arg_q;
    byte_cnt_d    = byte_cnt_q;
    data_d        = data_q;
    running_d     = running_q;
    cmd_error_d   = 1'b0;
    write_d       = 1'b0;
    address_d     = address_q;
    instruction_d = instruction_q;
    wreg_d        = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    raddr_d       = raddr_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          opcode_d = uart.i_rx_data;
          case (uart.i_rx_data)
            CMD_LOAD_INST, CMD_WRITE_REG: begin
              // writes would race the running pipeline, so they are refused
              if (running_q) cmd_error_d = 1'b1;
              else           state_d     = S_GET_ARG;
            end
            CMD_READ_REG: state_d   = S_GET_ARG;
            CMD_RUN:      running_d = 1'b1;
            CMD_STOP:     running_d = 1'b0;
            CMD_STEP: begin
              if (running_q) cmd_error_d = 1'b1;
              else           state_d     = S_STEP;
            end
            default:      cmd_error_d = 1'b1;
          endcase
        end
      end
      S_GET_ARG: begin
        if (rx_fire) begin
          arg_d      = uart.i_rx_data;
          byte_cnt_d = '0;
          if (opcode_q == CMD_READ_REG) begin
            raddr_d = uart.i_rx_data[NB_REG-1:0];
            state_d = S_READ_SETTLE;
          end else begin
            state_d = S_GET_DATA;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_fire) begin
          data_d = word_in[NB_SHIFT-1:0];
          if (byte_cnt_q == BYTE_CNT_W'(WORD_BYTES - 1)) begin
            state_d = S_DO_WRITE;
            if (opcode_q == CMD_LOAD_INST) begin
              write_d       = 1'b1;
              address_d     = NB_ADDR'(arg_q);
              instruction_d = NB_INST'(word_in);
            end else begin
              wreg_d  = 1'b1;
              waddr_d = arg_q[NB_REG-1:0];
              wdata_d = word_in;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_DO_WRITE:     state_d = S_IDLE;
      S_READ_SETTLE:  state_d = S_READ_CAPTURE;
      S_READ_CAPTURE: state_d = S_SEND;
      S_SEND:         if (ser_done) state_d = S_IDLE;
      S_STEP:         state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      opcode_q      <= '0;
      arg_q         <= '0;
      byte_cnt_q    <= '0;
      data_q        <= '0;
      running_q     <= 1'b0;
      cmd_error_q   <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= '0;
      instruction_q <= '0;
      wreg_q        <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      raddr_q       <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      arg_q         <= arg_d;
      byte_cnt_q    <= byte_cnt_d;
      data_q        <= data_d;
      running_q     <= running_d;
      cmd_error_q   <= cmd_error_d;
      write_q       <= write_d;
      address_q     <= address_d;
      instruction_q <= instruction_d;
      wreg_q        <= wreg_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      raddr_q       <= raddr_d;
    end
  end

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (state_q == S_READ_CAPTURE),
    .i_word     (i_data_read_debug),
    .o_tx_data  (uart.o_tx_data),
    .o_tx_valid (uart.o_tx_valid),
    .i_tx_ready (uart.i_tx_ready),
    .o_done     (ser_done)
  );

  assign uart.o_rx_ready        = rx_ready;
  assign o_enable               = running_q || (state_q == S_STEP);
  assign o_running              = running_q;
  assign o_cmd_error            = cmd_error_q;
  assign o_write                = write_q;
  assign o_address              = address_q;
  assign o_instruction          = instruction_q;
  assign o_write_debug_reg_file = wreg_q;
  assign o_address_write_debug  = waddr_q;
  assign o_write_data_debug     = wdata_q;
  assign o_address_read_debug   = raddr_q;

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - byte-stream reference model and scoreboard for debug_unit
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_enable, o_write, o_write_debug_reg_file, o_running, o_cmd_error;
  logic [31:0] o_address, o_instruction, o_write_data_debug, i_data_read_debug;
  logic [4:0]  o_address_write_debug, o_address_read_debug;

  always #5 clk = ~clk;

  debug_unit_if uart ();

  debug_unit dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .uart                   (uart),
    .o_enable               (o_enable),
    .o_write                (o_write),
    .o_address              (o_address),
    .o_instruction          (o_instruction),
    .o_write_debug_reg_file (o_write_debug_reg_file),
    .o_address_write_debug  (o_address_write_debug),
    .o_write_data_debug     (o_write_data_debug),
    .o_address_read_debug   (o_address_read_debug),
    .i_data_read_debug      (i_data_read_debug),
    .o_running              (o_running),
    .o_cmd_error            (o_cmd_error)
  );

  // processor stand-in: register file, instruction memory, and the first enabled
  // cycle retires the word at address 1 if it is an R-type add
  logic [31:0] env_regs [32];
  logic [31:0] env_imem [256];
  logic        env_started = 1'b0;
  logic [31:0] env_w;
  assign i_data_read_debug = env_regs[o_address_read_debug];

  always @(posedge clk) begin
    if (o_write_debug_reg_file) env_regs[o_address_write_debug] <= o_write_data_debug;
    if (o_write) env_imem[o_address[7:0]] <= o_instruction;
    if (o_enable && !env_started) begin
      env_w = env_imem[1];
      if (env_w[31:26] == 6'd0 && env_w[5:0] == 6'h20)
        env_regs[env_w[15:11]] <= env_regs[env_w[25:21]] + env_regs[env_w[20:16]];
      env_started <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_iw [$];
  logic [36:0] exp_rw [$];
  logic [7:0]  exp_tx [$];
  bit          exp_err [$];

  logic [31:0] m_regs [32];
  logic [31:0] m_imem [256];
  logic [7:0]  m_cmd [$];
  bit          m_running = 0;
  bit          m_started = 0;
  int          m_steps = 0;
  int          obs_steps = 0;
  int          tx_accepts = 0;
  bit          hold_low = 0;
  bit          rand_ready = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endfunction

  function automatic void m_first_enable();
    logic [31:0] w;
    if (!m_started) begin
      w = m_imem[1];
      if (w[31:26] == 6'd0 && w[5:0] == 6'h20)
        m_regs[w[15:11]] = m_regs[w[25:21]] + m_regs[w[20:16]];
      m_started = 1;
    end
  endfunction

  // interprets the host byte stream command by command
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0]  a;
    logic [31:0] w;
    if (m_cmd.size() == 0) begin
      case (b)
        8'h01, 8'h02: if (m_running) exp_err.push_back(1'b1); else m_cmd.push_back(b);
        8'h03: m_cmd.push_back(b);
        8'h04: begin m_running = 1; m_first_enable(); end
        8'h05: m_running = 0;
        8'h06: if (m_running) exp_err.push_back(1'b1);
               else begin m_steps++; m_first_enable(); end
        default: exp_err.push_back(1'b1);
      endcase
    end else begin
      m_cmd.push_back(b);
      a = m_cmd[1];
      if (m_cmd[0] == 8'h03 && m_cmd.size() == 2) begin
        w = m_regs[a[4:0]];
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
        m_cmd.delete();
      end else if (m_cmd.size() == 6) begin
        w = {m_cmd[2], m_cmd[3], m_cmd[4], m_cmd[5]};
        if (m_cmd[0] == 8'h01) begin
          exp_iw.push_back({24'd0, a, w});
          m_imem[a] = w;
        end else begin
          exp_rw.push_back({a[4:0], w});
          m_regs[a[4:0]] = w;
        end
        m_cmd.delete();
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (o_enable && !o_running) obs_steps++;
      if (o_write) begin
        check("iw_no_enable", {63'd0, o_enable}, 64'd0);
        if (exp_iw.size() == 0) fail("iw_unexpected");
        else check("iw_addr_data", {o_address, o_instruction}, exp_iw.pop_front());
      end
      if (o_write_debug_reg_file) begin
        check("rw_no_enable", {63'd0, o_enable}, 64'd0);
        if (exp_rw.size() == 0) fail("rw_unexpected");
        else check("rw_idx_data", {27'd0, o_address_write_debug, o_write_data_debug},
                   {27'd0, exp_rw.pop_front()});
      end
      if (o_cmd_error) begin
        if (exp_err.size() == 0) fail("cmd_error_unexpected");
        else begin
          checks++;
          void'(exp_err.pop_front());
        end
      end
    end
  end

  logic [7:0] tx_prev;
  bit         tx_stalled = 0;
  always @(negedge clk) begin
    if (!rst && uart.o_tx_valid) begin
      if (tx_stalled) check("tx_stable", {56'd0, uart.o_tx_data}, {56'd0, tx_prev});
      if (uart.i_tx_ready) begin
        tx_accepts++;
        if (exp_tx.size() == 0) fail("tx_unexpected");
        else check("tx_byte", {56'd0, uart.o_tx_data}, {56'd0, exp_tx.pop_front()});
      end
      tx_stalled = !uart.i_tx_ready;
      tx_prev    = uart.o_tx_data;
    end else begin
      tx_stalled = 0;
    end
  end

  initial begin
    uart.i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      uart.i_tx_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    bit ok = 0;
    model_byte(b);
    uart.i_rx_data  = b;
    uart.i_rx_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = uart.o_rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    if (!ok) fail("rx_accept_timeout");
    uart.i_rx_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) send(v[i*8 +: 8]);
  endtask

  task automatic quiesce();
    int n = 0;
    while ((exp_iw.size() + exp_rw.size() + exp_tx.size() + exp_err.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) fail("quiesce_timeout");
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_enable",  {63'd0, o_enable}, 64'd0);
    check("rst_write",   {63'd0, o_write}, 64'd0);
    check("rst_address", {32'd0, o_address}, 64'd0);
    check("rst_inst",    {32'd0, o_instruction}, 64'd0);
    check("rst_wreg",    {26'd0, o_write_debug_reg_file, o_address_write_debug, o_write_data_debug}, 64'd0);
    check("rst_raddr",   {59'd0, o_address_read_debug}, 64'd0);
    check("rst_running", {62'd0, o_running, o_cmd_error}, 64'd0);
    check("rst_rx_ready", {63'd0, uart.o_rx_ready}, 64'd0);
    check("rst_tx",      {55'd0, uart.o_tx_valid, uart.o_tx_data}, 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    for (int i = 0; i < 32; i++) begin env_regs[i] = 32'd0; m_regs[i] = 32'd0; end
    for (int i = 0; i < 256; i++) begin env_imem[i] = 32'd0; m_imem[i] = 32'd0; end
    rst = 1'b1;
    uart.i_rx_valid = 1'b0;
    uart.i_rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    send_n(6, 64'h0201_0000_0007);
    send_n(6, 64'h0202_0000_0008);
    quiesce();
    send_n(6, 64'h0101_0022_1820);
    quiesce();
    check("no_enable_before_step", 64'(obs_steps), 64'd0);

    send(8'h06);
    base = tx_accepts;
    send_n(2, 64'h0303);
    n = 0;
    while (tx_accepts == base && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail("tx_first_byte_timeout");
    hold_low = 1;
    repeat (5) @(posedge clk);
    hold_low = 0;
    quiesce();
    check("step_count", 64'(obs_steps), 64'(m_steps));

    send(8'h04);
    repeat (2) @(posedge clk);
    #1;
    check("running_after_run", {63'd0, o_running}, {63'd0, m_running});
    send_n(6, 64'h0205_0000_0001);
    send(8'h05);
    send_n(4, 64'h0);
    quiesce();
    check("enable_after_stop", {62'd0, o_enable, o_running}, {62'd0, m_running, m_running});

    send(8'hAB);
    send_n(2, 64'h0301);
    quiesce();

    send_n(5, 64'h01_09_11_22_33);
    rst = 1'b1;
    m_cmd.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    m_running = 0;
    send_n(6, 64'h010A_4455_6640);
    quiesce();

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [31:0] w;
      logic [7:0]  a;
      k = $urandom_range(0, 9);
      w = $urandom;
      a = 8'($urandom_range(0, 255));
      case (k)
        0, 1, 2: send_n(6, {16'd0, 8'h02, a, w});
        3: begin
          a = 8'($urandom_range(8, 127));
          send_n(6, {16'd0, 8'h01, a, w[31:6], 6'd0});
        end
        4, 5: send_n(2, {48'd0, 8'h03, a});
        6: send(8'h04);
        7: send(8'h05);
        8: send(8'h06);
        default: send(a < 8'h07 ? 8'h00 : a);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
    end
    quiesce();

    check("left_iw", 64'(exp_iw.size()), 64'd0);
    check("left_rw", 64'(exp_rw.size()), 64'd0);
    check("left_tx", 64'(exp_tx.size()), 64'd0);
    check("left_err", 64'(exp_err.size()), 64'd0);
    check("final_steps", 64'(obs_steps), 64'(m_steps));
    check("final_running", {63'd0, o_running}, {63'd0, m_running});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
